mem_wb_commit: RTL and testbench

- Registered writeback stage sitting directly downstream of the MEM/WB control decode.
- Captures one retiring instruction per cycle: ALU result, PC+4, rd and decoded WBSel/RegWEn.
- For loads, waits for the dcache response, extracts and sign/zero-extends the addressed byte/half/word, then drives the regfile write port and the forwarding bus.
- Stalls upstream while a load response is outstanding and counts stall cycles for performance reporting.

---
 rtl/mem_wb_commit_pkg.sv | 29 ++
 rtl/mem_wb_commit_load_extract.sv | 31 +++
 rtl/mem_wb_commit.sv | 121 ++++++++++++
 tb/tb_mem_wb_commit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_commit_pkg.sv
// Shared constants and types for the MEM/WB commit stage and its load extractor.
package mem_wb_commit_pkg;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;

  localparam logic [2:0] FUNCT3_BYTE  = 3'b000;
  localparam logic [2:0] FUNCT3_HALF  = 3'b001;
  localparam logic [2:0] FUNCT3_WORD  = 3'b010;
  localparam logic [2:0] FUNCT3_BYTEU = 3'b100;
  localparam logic [2:0] FUNCT3_HALFU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_HOLD      = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_commit_load_extract.sv
// Combinational load-data extractor: picks the addressed byte/half/word out of an
// aligned dcache word and sign- or zero-extends it. Shared with the forwarding path.
module load_extract
  import mem_wb_commit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dcache_dout,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dcache_dout[{addr_lsb, 3'b000} +: 8];
  assign half_sel = addr_lsb[1] ? dcache_dout[31:16] : dcache_dout[15:0];

  always_comb begin
    case (funct3)
      FUNCT3_BYTE:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_BYTEU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_HALF:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_HALFU: load_data = {{(XLEN-16){1'b0}}, half_sel};
      // Undefined load sizes behave as a full-word load.
      default:      load_data = dcache_dout;
    endcase
  end

endmodule

// File: rtl/mem_wb_commit.sv
// Registered writeback stage: captures one retiring instruction, waits for load data
// when needed, and drives the regfile write port plus a saturating stall counter.
module mem_wb_commit
  import mem_wb_commit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lsb,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_pc_plus4,
  input  logic [4:0]           in_rd,
  input  logic [1:0]           in_wbsel,
  input  logic                 in_regwen,
  input  logic                 dcache_resp_valid,
  input  logic [XLEN-1:0]      dcache_dout,
  output logic                 rf_we,
  output logic [4:0]           rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic                 stall,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  input  logic                 stall_cnt_clr
);

  state_e                state_q, state_d;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lsb_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       pc4_q;
  logic [4:0]            rd_q;
  logic [1:0]            wbsel_q;
  logic                  regwen_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic                  capture;
  logic                  committing;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       wd_sel;

  assign stall      = (state_q == ST_WAIT_LOAD) && !dcache_resp_valid;
  assign in_ready   = !stall;
  assign capture    = in_valid && in_ready;
  assign committing = (state_q == ST_HOLD) || ((state_q == ST_WAIT_LOAD) && dcache_resp_valid);

  always_comb begin
    state_d = ST_EMPTY;
    if (capture)
      state_d = (in_opcode == OP_LOAD) ? ST_WAIT_LOAD : ST_HOLD;
    else if (stall)
      state_d = ST_WAIT_LOAD;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr)
      stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      opcode_q    <= '0;
      funct3_q    <= '0;
      addr_lsb_q  <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
      wbsel_q     <= '0;
      regwen_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (capture) begin
        opcode_q   <= in_opcode;
        funct3_q   <= in_funct3;
        addr_lsb_q <= in_addr_lsb;
        alu_q      <= in_alu_result;
        pc4_q      <= in_pc_plus4;
        rd_q       <= in_rd;
        wbsel_q    <= in_wbsel;
        regwen_q   <= in_regwen;
      end
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .dcache_dout (dcache_dout),
    .funct3      (funct3_q),
    .addr_lsb    (addr_lsb_q),
    .load_data   (load_data)
  );

  always_comb begin
    case (wbsel_q)
      WB_ALU:  wd_sel = alu_q;
      WB_PC4:  wd_sel = pc4_q;
      WB_MEM:  wd_sel = load_data;
      default: wd_sel = '0;
    endcase
  end

  // Stores and branches never write back even if the decoder flagged RegWEn.
  assign rf_we = committing && regwen_q && (rd_q != 5'd0) &&
                 (opcode_q != OP_STORE) && (opcode_q != OP_BRANCH) &&
                 (wbsel_q != 2'b11);
  assign rf_wa = committing ? rd_q : 5'd0;
  assign rf_wd = committing ? wd_sel : '0;

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_commit.sv
// Directed bench for mem_wb_commit; a second instance with a 3-bit counter checks saturation.
module tb_mem_wb_commit;
  import mem_wb_commit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lsb = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_pc_plus4 = '0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_wbsel = '0;
  logic        in_regwen = 1'b0;
  logic        dcache_resp_valid = 1'b0;
  logic [31:0] dcache_dout = '0;
  logic        rf_we, rf_we_s;
  logic [4:0]  rf_wa, rf_wa_s;
  logic [31:0] rf_wd, rf_wd_s;
  logic        stall, stall_s;
  logic [31:0] stall_cnt;
  logic [2:0]  stall_cnt_s;
  logic        stall_cnt_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_commit #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_addr_lsb(in_addr_lsb),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_rd(in_rd),
    .in_wbsel(in_wbsel), .in_regwen(in_regwen), .dcache_resp_valid(dcache_resp_valid),
    .dcache_dout(dcache_dout), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .stall(stall), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
  );

  mem_wb_commit #(.XLEN(32), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_addr_lsb(in_addr_lsb),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_rd(in_rd),
    .in_wbsel(in_wbsel), .in_regwen(in_regwen), .dcache_resp_valid(dcache_resp_valid),
    .dcache_dout(dcache_dout), .rf_we(rf_we_s), .rf_wa(rf_wa_s), .rf_wd(rf_wd_s),
    .stall(stall_s), .stall_cnt(stall_cnt_s), .stall_cnt_clr(stall_cnt_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    dcache_resp_valid = 1'b0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [1:0] wbsel, input logic regwen);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_addr_lsb = lsb;
    in_alu_result = alu; in_pc_plus4 = pc4; in_rd = rd; in_wbsel = wbsel; in_regwen = regwen;
  endtask

  // Load with an immediate response in the first cycle after capture.
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] dout, input logic [31:0] exp);
    issue(OP_LOAD, f3, lsb, 32'h0, 32'h0, 5'd12, WB_MEM, 1'b1);
    tick();
    idle();
    dcache_resp_valid = 1'b1;
    dcache_dout = dout;
    settle();
    check({tag, "_we"}, {31'b0, rf_we}, 32'd1);
    check({tag, "_wd"}, rf_wd, exp);
    tick();
    idle();
  endtask

  initial begin
    // Reset state
    settle();
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_rf_wa", {27'b0, rf_wa}, 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // ALU op: one-cycle commit, then idle
    issue(OP_ARI_RTYPE, 3'b000, 2'b00, 32'h0000_1234, 32'h0, 5'd5, WB_ALU, 1'b1);
    tick(); idle(); settle();
    check("alu_we", {31'b0, rf_we}, 32'd1);
    check("alu_wa", {27'b0, rf_wa}, 32'd5);
    check("alu_wd", rf_wd, 32'h0000_1234);
    tick();
    check("alu_we_after", {31'b0, rf_we}, 32'd0);
    check("alu_wd_after", rf_wd, 32'd0);

    // lb with 3 stall cycles
    issue(OP_LOAD, FUNCT3_BYTE, 2'd3, 32'h0, 32'h0, 5'd6, WB_MEM, 1'b1);
    tick(); idle(); dcache_dout = 32'h80FF_0000; settle();
    check("lb_stall", {31'b0, stall}, 32'd1);
    check("lb_in_ready", {31'b0, in_ready}, 32'd0);
    check("lb_we_wait", {31'b0, rf_we}, 32'd0);
    tick(); tick(); tick();
    dcache_resp_valid = 1'b1; settle();
    check("lb_stall_cnt", stall_cnt, 32'd3);
    check("lb_stall_resp", {31'b0, stall}, 32'd0);
    check("lb_we", {31'b0, rf_we}, 32'd1);
    check("lb_wa", {27'b0, rf_wa}, 32'd6);
    check("lb_wd", rf_wd, 32'hFFFF_FF80);
    tick(); idle(); settle();
    check("lb_we_after", {31'b0, rf_we}, 32'd0);

    // Extraction variants
    load_op("lhu", FUNCT3_HALFU, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
    load_op("lh", FUNCT3_HALF, 2'd2, 32'hBEEF_1234, 32'hFFFF_BEEF);
    load_op("lbu", FUNCT3_BYTEU, 2'd1, 32'h1234_5678, 32'h0000_0056);
    load_op("lh_lo", FUNCT3_HALF, 2'd0, 32'h1234_8001, 32'hFFFF_8001);
    load_op("lw_f3odd", 3'b011, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Store never writes; JAL to x0 never writes; JAL to x1 writes link
    issue(OP_STORE, 3'b010, 2'd0, 32'h55, 32'h0, 5'd7, WB_ALU, 1'b1);
    tick(); idle(); settle();
    check("store_we", {31'b0, rf_we}, 32'd0);
    issue(OP_JAL, 3'b000, 2'd0, 32'h0, 32'h100, 5'd0, WB_PC4, 1'b1);
    tick(); idle(); settle();
    check("jal_x0_we", {31'b0, rf_we}, 32'd0);
    issue(OP_JAL, 3'b000, 2'd0, 32'h0, 32'h100, 5'd1, WB_PC4, 1'b1);
    tick(); idle(); settle();
    check("jal_x1_we", {31'b0, rf_we}, 32'd1);
    check("jal_x1_wd", rf_wd, 32'h0000_0100);
    issue(OP_ARI_ITYPE, 3'b000, 2'd0, 32'h77, 32'h0, 5'd3, 2'b11, 1'b1);
    tick(); idle(); settle();
    check("wbsel11_we", {31'b0, rf_we}, 32'd0);
    check("wbsel11_wd", rf_wd, 32'd0);
    tick();

    // Stray response while EMPTY is ignored
    dcache_resp_valid = 1'b1; dcache_dout = 32'h1111_1111; settle();
    check("stray_resp_we", {31'b0, rf_we}, 32'd0);
    tick(); idle();

    // Back-to-back: load response coincides with new ALU capture
    issue(OP_LOAD, FUNCT3_WORD, 2'd0, 32'h0, 32'h0, 5'd8, WB_MEM, 1'b1);
    tick(); idle(); settle();
    check("b2b_stall", {31'b0, stall}, 32'd1);
    tick();
    dcache_resp_valid = 1'b1; dcache_dout = 32'hCAFE_F00D;
    issue(OP_ARI_RTYPE, 3'b000, 2'd0, 32'h55, 32'h0, 5'd9, WB_ALU, 1'b1);
    settle();
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    check("b2b_load_wa", {27'b0, rf_wa}, 32'd8);
    check("b2b_load_wd", rf_wd, 32'hCAFE_F00D);
    tick(); idle(); settle();
    check("b2b_alu_we", {31'b0, rf_we}, 32'd1);
    check("b2b_alu_wa", {27'b0, rf_wa}, 32'd9);
    check("b2b_alu_wd", rf_wd, 32'h0000_0055);
    check("b2b_stall_cnt", stall_cnt, 32'd4);
    tick();

    // Reset mid-WAIT_LOAD, late response ignored
    issue(OP_LOAD, FUNCT3_WORD, 2'd0, 32'h0, 32'h0, 5'd10, WB_MEM, 1'b1);
    tick(); idle(); settle();
    check("rstw_stall_pre", {31'b0, stall}, 32'd1);
    #2 reset_n = 1'b0; settle();
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_in_ready", {31'b0, in_ready}, 32'd1);
    check("rstw_stall_cnt", stall_cnt, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    dcache_resp_valid = 1'b1; dcache_dout = 32'h2222_2222; settle();
    check("rstw_late_we", {31'b0, rf_we}, 32'd0);
    check("rstw_late_wa", {27'b0, rf_wa}, 32'd0);
    tick(); idle();

    // Long stall: 3-bit counter saturates; clear wins over increment
    issue(OP_LOAD, FUNCT3_WORD, 2'd0, 32'h0, 32'h0, 5'd11, WB_MEM, 1'b1);
    tick(); idle();
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt_small", {29'b0, stall_cnt_s}, 32'd7);
    check("sat_cnt_wide", stall_cnt, 32'd10);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0; settle();
    check("clr_cnt_small", {29'b0, stall_cnt_s}, 32'd0);
    check("clr_cnt_wide", stall_cnt, 32'd0);
    check("clr_still_stall", {31'b0, stall}, 32'd1);
    tick(); settle();
    check("post_clr_cnt", stall_cnt, 32'd1);
    dcache_resp_valid = 1'b1; dcache_dout = 32'h0BAD_CAFE; settle();
    check("sat_load_wd", rf_wd, 32'h0BAD_CAFE);
    tick(); idle(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
